// File: rtl/led_mode_ctrl.sv
// LED pattern controller: prescaled step strobe driving LEFT/RIGHT/PINGPONG/BLINK patterns.
// Optional BLINK mode is built only when LED_BLINK_MODE_EN is defined.
module led_mode_ctrl #(
    parameter int unsigned TICK_MAX = 24_999_999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_next,
    input  logic       pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       tick
);

`ifdef LED_BLINK_MODE_EN
    typedef enum logic [1:0] {StLeft = 2'd0, StRight = 2'd1, StPingpong = 2'd2, StBlink = 2'd3}
        state_e;
`else
    typedef enum logic [1:0] {StLeft = 2'd0, StRight = 2'd1, StPingpong = 2'd2} state_e;
`endif

    state_e      state_q, state_d, state_nxt;
    logic [7:0]  led_q, led_d, step_led, seed_led;
    logic [31:0] cnt_q, cnt_d;
    logic        dir_q, dir_d, step_dir;  // dir: 1 = toward MSB
    logic        tick_q, tick_d;

    // Mode sequence and seed of the mode being entered.
    always_comb begin
        state_nxt = StLeft;
        seed_led  = 8'h01;
        case (state_q)
            StLeft:     state_nxt = StRight;
`ifdef LED_BLINK_MODE_EN
            StPingpong: state_nxt = StBlink;
            StBlink:    state_nxt = StLeft;
`else
            StPingpong: state_nxt = StLeft;
`endif
            default:    state_nxt = StPingpong;
        endcase
        case (state_nxt)
            StRight: seed_led = 8'h80;
`ifdef LED_BLINK_MODE_EN
            StBlink: seed_led = 8'hff;
`endif
            default: seed_led = 8'h01;
        endcase
    end

    // Pattern advance applied on a prescaler terminal count.
    always_comb begin
        step_led = led_q;
        step_dir = dir_q;
        case (state_q)
            StLeft:  step_led = {led_q[6:0], led_q[7]};
            StRight: step_led = {led_q[0], led_q[7:1]};
            StPingpong: begin
                if (led_q == 8'h80) begin
                    step_dir = 1'b0;
                    step_led = {1'b0, led_q[7:1]};
                end else if (led_q == 8'h01) begin
                    step_dir = 1'b1;
                    step_led = {led_q[6:0], 1'b0};
                end else if (dir_q) begin
                    step_led = {led_q[6:0], 1'b0};
                end else begin
                    step_led = {1'b0, led_q[7:1]};
                end
            end
`ifdef LED_BLINK_MODE_EN
            StBlink: step_led = ~led_q;
`endif
            default: step_led = led_q;
        endcase
    end

    // mode_next has priority over pause and over a coincident terminal count.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (mode_next) begin
            state_d = state_nxt;
            led_d   = seed_led;
            cnt_d   = 32'd0;
            dir_d   = 1'b1;
        end else if (!pause) begin
            if (cnt_q == TICK_MAX) begin
                cnt_d  = 32'd0;
                tick_d = 1'b1;
                led_d  = step_led;
                dir_d  = step_dir;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLeft;
            led_q   <= 8'h01;
            cnt_q   <= 32'd0;
            dir_q   <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end

    assign led  = led_q;
    assign mode = state_q;
    assign tick = tick_q;

endmodule
